// File: rtl/sdr_16_pkg.sv
// Shared definitions for the sdr_16 controller and its SDRAM responder model:
// command encodings, mode-register fields and sticky error flag indices.
package sdr_16_pkg;

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PCH = 3'b010;
   localparam logic [2:0] CMD_RFR = 3'b001;
   localparam logic [2:0] CMD_LMR = 3'b000;

   localparam int MR_BL_LSB = 0;
   localparam int MR_BT_BIT = 3;
   localparam int MR_CL_LSB = 4;
   localparam int MR_WB_BIT = 9;
   localparam int A_AP_BIT  = 10;

   localparam logic [2:0] BL_1  = 3'b000;
   localparam logic [2:0] BL_2  = 3'b001;
   localparam logic [2:0] BL_4  = 3'b010;
   localparam logic [2:0] BL_8  = 3'b011;
   localparam logic [2:0] BL_FP = 3'b111;

   localparam int ERR_ACT_OPEN  = 0;
   localparam int ERR_RW_CLOSED = 1;
   localparam int ERR_REF_OPEN  = 2;
   localparam int ERR_MODE      = 3;
   localparam int ERR_PREINIT   = 4;

   typedef struct packed {
      logic [2:0] cl;
      logic [2:0] bl;
      logic       bt;
      logic       wb;
   } mode_t;

   localparam mode_t MODE_RESET = '{cl: 3'd3, bl: BL_1, bt: 1'b0, wb: 1'b0};

   function automatic mode_t decode_mode(input logic [12:0] m);
      decode_mode = '{cl: m[MR_CL_LSB +: 3], bl: m[MR_BL_LSB +: 3],
                      bt: m[MR_BT_BIT], wb: m[MR_WB_BIT]};
   endfunction

   // Full page is only defined for sequential bursts.
   function automatic logic mode_legal(input logic [12:0] m);
      mode_t md;
      md = decode_mode(m);
      mode_legal = (md.cl == 3'd2 || md.cl == 3'd3) &&
                   (md.bl == BL_1 || md.bl == BL_2 || md.bl == BL_4 ||
                    md.bl == BL_8 || md.bl == BL_FP) &&
                   !(md.bl == BL_FP && md.bt);
   endfunction

endpackage

// File: rtl/sdr_16_mem.sv
// Responder storage: one byte-enabled write port and one registered read port.
// A read and write to the same address on one edge return the old word.
module sdr_16_mem #(
   parameter int AW = 10
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [1:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [15:0]   i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [15:0]   o_rdata
);

   logic [15:0] r_mem [2**AW];

   always_ff @(posedge i_clk) begin
      if (i_we && i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
      if (i_we && i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
      if (i_re)            o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/sdr_16_responder.sv
// Behavioural SDR SDRAM responder for the sdr_16 controller: bank tracking,
// mode register, burst address generation, CL read pipeline and error flags.
module sdr_16_responder
   import sdr_16_pkg::*;
#(
   parameter int ROW_LSBS = 2,
   parameter int COL_LSBS = 6
) (
   input  logic        sdram_clk,
   input  logic        sdram_rst,
   input  logic [1:0]  ba,
   input  logic [12:0] a,
   input  logic [2:0]  cmd,
   input  logic [1:0]  dqm,
   input  logic [15:0] dq_i,
   output logic [15:0] dq_o,
   output logic        dq_oe_o,
   output logic        init_done,
   output logic [15:0] rfr_cnt,
   output logic [4:0]  err
);

   localparam int AW = 2 + ROW_LSBS + COL_LSBS;

   logic [3:0]          r_open;
   logic [ROW_LSBS-1:0] r_row [4];
   mode_t               r_mode;
   logic                r_bst_act, r_bst_wr, r_bst_fp, r_bst_bt;
   logic [1:0]          r_bst_ba;
   logic [COL_LSBS-1:0] r_bst_start;
   logic [COL_LSBS:0]   r_bst_beat;
   logic [3:0]          r_bst_len;
   logic                r_rd_v1, r_rd_v2, r_dqm_d1, r_dqm_d2;
   logic [15:0]         r_s2;

   logic w_is_act, w_is_rd, w_is_wr, w_is_pch, w_is_rfr, w_is_lmr, w_rw;
   logic w_start, w_cont, w_pch_kill, w_acc_wr, w_we, w_re, w_fp, w_out_v;
   logic [3:0]          w_len;
   logic [1:0]          w_acc_ba;
   logic [COL_LSBS-1:0] w_beat_lo, w_mask, w_cont_col, w_acc_col;
   logic [COL_LSBS:0]   w_beat_nxt;
   logic [AW-1:0]       w_addr;
   logic [15:0]         w_mem_q, w_out_d;
   logic                w_unused;

   assign w_is_act = (cmd == CMD_ACT);
   assign w_is_rd  = (cmd == CMD_RD);
   assign w_is_wr  = (cmd == CMD_WR);
   assign w_is_pch = (cmd == CMD_PCH);
   assign w_is_rfr = (cmd == CMD_RFR);
   assign w_is_lmr = (cmd == CMD_LMR);
   assign w_rw     = w_is_rd || w_is_wr;
   assign w_unused = ^{a[12:11], a[8:7]};

   assign w_start    = w_rw && r_open[ba];
   assign w_pch_kill = w_is_pch && (a[A_AP_BIT] || ba == r_bst_ba);
   assign w_cont     = r_bst_act && !w_rw && !w_pch_kill;

   // Continuing beats: full page wraps the row, interleave XORs, sequential
   // wraps inside the aligned block.
   assign w_beat_lo  = r_bst_beat[COL_LSBS-1:0];
   assign w_beat_nxt = r_bst_beat + 1'b1;
   assign w_mask     = COL_LSBS'(r_bst_len - 4'd1);
   assign w_cont_col = r_bst_fp ? r_bst_start + w_beat_lo :
                       r_bst_bt ? r_bst_start ^ w_beat_lo :
                       (r_bst_start & ~w_mask) | ((r_bst_start + w_beat_lo) & w_mask);

   always_comb begin
      w_len = 4'd1;
      case (r_mode.bl)
         BL_2:    w_len = 4'd2;
         BL_4:    w_len = 4'd4;
         BL_8:    w_len = 4'd8;
         default: w_len = 4'd1;
      endcase
      w_fp = (r_mode.bl == BL_FP);
      if (w_is_wr && r_mode.wb) begin
         w_len = 4'd1;
         w_fp  = 1'b0;
      end
   end

   assign w_acc_ba  = w_start ? ba : r_bst_ba;
   assign w_acc_col = w_start ? a[COL_LSBS-1:0] : w_cont_col;
   assign w_acc_wr  = w_start ? w_is_wr : r_bst_wr;
   assign w_we      = (w_start || w_cont) && w_acc_wr && !sdram_rst;
   assign w_re      = (w_start || w_cont) && !w_acc_wr && !sdram_rst;
   assign w_addr    = {w_acc_ba, r_row[w_acc_ba], w_acc_col};

   sdr_16_mem #(.AW(AW)) u_mem (
      .i_clk   (sdram_clk),
      .i_we    (w_we),
      .i_be    (~dqm),
      .i_waddr (w_addr),
      .i_wdata (dq_i),
      .i_re    (w_re),
      .i_raddr (w_addr),
      .o_rdata (w_mem_q)
   );

   // The memory itself supplies one stage; CL3 adds r_s2.
   assign w_out_v = (r_mode.cl == 3'd2) ? r_rd_v1 : r_rd_v2;
   assign w_out_d = (r_mode.cl == 3'd2) ? w_mem_q : r_s2;

   always_ff @(posedge sdram_clk) begin
      if (!sdram_rst && w_is_act) r_row[ba] <= a[ROW_LSBS-1:0];
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         r_open      <= '0;
         r_mode      <= MODE_RESET;
         r_bst_act   <= 1'b0;
         r_bst_wr    <= 1'b0;
         r_bst_fp    <= 1'b0;
         r_bst_bt    <= 1'b0;
         r_bst_ba    <= '0;
         r_bst_start <= '0;
         r_bst_beat  <= '0;
         r_bst_len   <= 4'd1;
         r_rd_v1     <= 1'b0;
         r_rd_v2     <= 1'b0;
         r_dqm_d1    <= 1'b0;
         r_dqm_d2    <= 1'b0;
         r_s2        <= '0;
         dq_o        <= '0;
         dq_oe_o     <= 1'b0;
         init_done   <= 1'b0;
         rfr_cnt     <= '0;
         err         <= '0;
      end else begin
         r_dqm_d1 <= |dqm;
         r_dqm_d2 <= r_dqm_d1;
         r_rd_v1  <= w_re;
         r_rd_v2  <= r_rd_v1 && !w_is_wr;
         r_s2     <= w_mem_q;
         if (w_is_wr) begin
            dq_oe_o <= 1'b0;
         end else begin
            dq_oe_o <= w_out_v && !r_dqm_d2;
            if (w_out_v) dq_o <= w_out_d;
         end

         if (w_rw) begin
            r_bst_act   <= w_start && (w_fp || w_len != 4'd1);
            r_bst_wr    <= w_is_wr;
            r_bst_ba    <= ba;
            r_bst_start <= a[COL_LSBS-1:0];
            r_bst_beat  <= (COL_LSBS+1)'(1);
            r_bst_len   <= w_len;
            r_bst_fp    <= w_fp;
            r_bst_bt    <= r_mode.bt;
            if (!r_open[ba]) err[ERR_RW_CLOSED] <= 1'b1;
            if (!init_done)  err[ERR_PREINIT]   <= 1'b1;
         end else if (w_pch_kill) begin
            r_bst_act <= 1'b0;
         end else if (w_cont) begin
            r_bst_beat <= w_beat_nxt;
            if (!r_bst_fp && w_beat_nxt == (COL_LSBS+1)'(r_bst_len)) r_bst_act <= 1'b0;
         end

         if (w_is_act) begin
            if (r_open[ba]) err[ERR_ACT_OPEN] <= 1'b1;
            if (!init_done) err[ERR_PREINIT]  <= 1'b1;
            r_open[ba] <= 1'b1;
         end
         if (w_is_pch) begin
            if (a[A_AP_BIT]) r_open <= '0;
            else             r_open[ba] <= 1'b0;
         end
         if (w_is_rfr) begin
            if (|r_open) err[ERR_REF_OPEN] <= 1'b1;
            if (rfr_cnt != 16'hFFFF) rfr_cnt <= rfr_cnt + 16'd1;
         end
         if (w_is_lmr) begin
            if (|r_open) err[ERR_REF_OPEN] <= 1'b1;
            if (mode_legal(a)) begin
               r_mode <= decode_mode(a);
               if (rfr_cnt >= 16'd2) init_done <= 1'b1;
            end else begin
               err[ERR_MODE] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdr_16_responder.sv
// Directed bench for sdr_16_responder; read words are checked against a
// scoreboard of (edge, data) entries queued when the RD is issued.
module tb_sdr_16_responder;
   import sdr_16_pkg::*;

   logic        sdram_clk = 1'b0;
   logic        sdram_rst = 1'b1;
   logic [1:0]  ba = '0;
   logic [12:0] a = '0;
   logic [2:0]  cmd = CMD_NOP;
   logic [1:0]  dqm = '0;
   logic [15:0] dq_i = '0;
   logic [15:0] dq_o;
   logic        dq_oe_o;
   logic        init_done;
   logic [15:0] rfr_cnt;
   logic [4:0]  err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int r;

   typedef struct {
      string       tag;
      int          at_edge;
      logic [15:0] data;
   } exp_t;
   exp_t exp_q[$];

   sdr_16_responder #(.ROW_LSBS(2), .COL_LSBS(6)) dut (
      .sdram_clk (sdram_clk),
      .sdram_rst (sdram_rst),
      .ba        (ba),
      .a         (a),
      .cmd       (cmd),
      .dqm       (dqm),
      .dq_i      (dq_i),
      .dq_o      (dq_o),
      .dq_oe_o   (dq_oe_o),
      .init_done (init_done),
      .rfr_cnt   (rfr_cnt),
      .err       (err)
   );

   always #5 sdram_clk = ~sdram_clk;
   always @(posedge sdram_clk) cyc <= cyc + 1;

   // Each driven word must be the next scoreboard entry, on its expected edge.
   always @(negedge sdram_clk) begin : mon
      exp_t e;
      if (dq_oe_o === 1'b1) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL rd_unexpected observed=%h@%0d expected=none", dq_o, cyc);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            assert (dq_o === e.data && cyc == e.at_edge) else begin
               n_fail++;
               $error("FAIL %s observed=%h@%0d expected=%h@%0d", e.tag, dq_o, cyc, e.data, e.at_edge);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                       input logic [1:0] m, input logic [15:0] d);
      cmd = c; ba = b; a = ad; dqm = m; dq_i = d;
      @(posedge sdram_clk);
      #1;
      cmd = CMD_NOP; dqm = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
   endtask

   task automatic push(input string tag, input int at, input logic [15:0] d);
      exp_t e;
      e.tag = tag; e.at_edge = at; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 30; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge sdram_clk);
         #1;
      end
      chk({tag, "_drain"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      sdram_rst = 1'b1;
      idle(3);
      sdram_rst = 1'b0;
      chk("rst_dq_o", dq_o, 0);
      chk("rst_oe", dq_oe_o, 0);
      chk("rst_init", init_done, 0);
      chk("rst_rfr", rfr_cnt, 0);
      chk("rst_err", err, 0);

      // init: PCH all, RFR x2, LMR CL2 BL4
      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_RFR, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_RFR, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      chk("init_done", init_done, 1);
      chk("init_rfr", rfr_cnt, 2);
      chk("init_err", err, 0);

      // CL2 BL4 write/read with a masked low byte on beat 2
      step(CMD_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
      step(CMD_WR, 2'd1, 13'h004, 2'b00, 16'hA0A0);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'hA1A1);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'hA2A2);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'hA3A3);
      idle(2);
      step(CMD_WR, 2'd1, 13'h405, 2'b00, 16'h1111);
      step(CMD_NOP, 2'd0, 13'h0, 2'b01, 16'h2222);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h3333);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h4444);
      idle(2);
      step(CMD_RD, 2'd1, 13'h405, 2'b00, 16'h0);
      r = cyc;
      push("bl4_c5", r + 1, 16'h1111);
      push("bl4_c6", r + 2, 16'h22A2);
      push("bl4_c7", r + 3, 16'h3333);
      push("bl4_c4", r + 4, 16'h4444);
      drain("bl4");

      // WR right after RD flushes the in-flight read words
      step(CMD_RD, 2'd1, 13'h005, 2'b00, 16'h0);
      step(CMD_WR, 2'd1, 13'h010, 2'b00, 16'h5555);
      chk("flush_oe0", dq_oe_o, 0);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h5555);
      chk("flush_oe1", dq_oe_o, 0);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h5555);
      chk("flush_oe2", dq_oe_o, 0);
      idle(3);

      // CL3: dqm on the edge after RD blanks the second word
      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h032, 2'b00, 16'h0);
      step(CMD_ACT, 2'd1, 13'h003, 2'b00, 16'h0);
      step(CMD_RD, 2'd1, 13'h005, 2'b00, 16'h0);
      r = cyc;
      step(CMD_NOP, 2'd0, 13'h0, 2'b11, 16'h0);
      push("cl3_w0", r + 2, 16'h1111);
      push("cl3_w2", r + 4, 16'h3333);
      push("cl3_w3", r + 5, 16'h4444);
      drain("cl3");

      // full page: fill row 0 of bank 0, then RD terminated by a new RD
      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h027, 2'b00, 16'h0);
      step(CMD_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_WR, 2'd0, 13'h000, 2'b00, 16'hC000);
      for (int k = 1; k < 64; k++) step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'hC000 + 16'(k));
      step(CMD_RD, 2'd0, 13'h03E, 2'b00, 16'h0);
      r = cyc;
      push("fp_3e", r + 1, 16'hC03E);
      push("fp_3f", r + 2, 16'hC03F);
      push("fp_00", r + 3, 16'hC000);
      idle(2);
      step(CMD_RD, 2'd0, 13'h010, 2'b00, 16'h0);
      push("fp_10", r + 4, 16'hC010);
      push("fp_11", r + 5, 16'hC011);
      push("fp_12", r + 6, 16'hC012);
      idle(2);
      step(CMD_PCH, 2'd0, 13'h000, 2'b00, 16'h0);
      drain("fp");

      // error flags
      step(CMD_RD, 2'd2, 13'h000, 2'b00, 16'h0);
      chk("err_rd_closed", err, 5'b00010);
      step(CMD_ACT, 2'd3, 13'h000, 2'b00, 16'h0);
      step(CMD_ACT, 2'd3, 13'h000, 2'b00, 16'h0);
      chk("err_act_open", err, 5'b00011);
      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h052, 2'b00, 16'h0);
      chk("err_mode", err, 5'b01011);
      step(CMD_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_RD, 2'd0, 13'h001, 2'b00, 16'h0);
      r = cyc;
      push("kept_c1", r + 1, 16'hC001);
      push("kept_c2", r + 2, 16'hC002);
      idle(1);
      step(CMD_PCH, 2'd0, 13'h000, 2'b00, 16'h0);
      drain("kept");

      // reset in the middle of a write burst
      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      step(CMD_ACT, 2'd2, 13'h001, 2'b00, 16'h0);
      step(CMD_WR, 2'd2, 13'h008, 2'b00, 16'h7000);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h7001);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h7002);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h7003);
      idle(2);
      step(CMD_WR, 2'd2, 13'h008, 2'b00, 16'h8000);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h8001);
      sdram_rst = 1'b1;
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h8002);
      step(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h8003);
      sdram_rst = 1'b0;
      chk("rst2_dq_o", dq_o, 0);
      chk("rst2_oe", dq_oe_o, 0);
      chk("rst2_init", init_done, 0);
      chk("rst2_rfr", rfr_cnt, 0);
      chk("rst2_err", err, 0);
      step(CMD_ACT, 2'd2, 13'h001, 2'b00, 16'h0);
      chk("err_preinit", err, 5'b10000);
      // default mode is CL3 BL1
      step(CMD_RD, 2'd2, 13'h008, 2'b00, 16'h0);
      r = cyc;
      push("dflt_c8", r + 2, 16'h8000);
      drain("dflt");

      step(CMD_PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      step(CMD_RFR, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_RFR, 2'd0, 13'h000, 2'b00, 16'h0);
      step(CMD_LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      chk("reinit_done", init_done, 1);
      step(CMD_ACT, 2'd2, 13'h001, 2'b00, 16'h0);
      step(CMD_RD, 2'd2, 13'h008, 2'b00, 16'h0);
      r = cyc;
      push("abort_c8", r + 1, 16'h8000);
      push("abort_c9", r + 2, 16'h8001);
      push("abort_ca", r + 3, 16'h7002);
      push("abort_cb", r + 4, 16'h7003);
      drain("abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sdr_16_responder.md
SDR_16_RESPONDER -- requirements
Module: sdr_16_responder

Interface
REQ-001 Parameter ROW_LSBS, 2, number of low row bits that index storage.
REQ-002 Parameter COL_LSBS, 6, number of low column bits that index storage.
REQ-003 sdram_clk  in  1  single clock; all inputs are sampled and all outputs are registered on its rising edge.
REQ-004 sdram_rst  in  1  reset; synchronous, active-high.
REQ-005 ba  in  2  bank address.
REQ-006 a  in  13  row, column or mode address.
REQ-007 cmd  in  3  command {ras_n,cas_n,we_n}: nop 111, act 011, rd 101, wr 100, pch 010, rfr 001, lmr 000.
REQ-008 dqm  in  2  byte masks; bit1 masks dq[15:8], bit0 masks dq[7:0].
REQ-009 dq_i  in  16  write data from the controller.
REQ-010 dq_o  out  16  read data.
REQ-011 dq_oe_o  out  1  read data valid and driven.
REQ-012 init_done  out  1  initialisation sequence completed.
REQ-013 rfr_cnt  out  16  count of RFR commands, saturating.
REQ-014 err  out  5  sticky protocol-violation flags.

Function
REQ-015 Storage SHALL be 2^(2+ROW_LSBS+COL_LSBS) x 16 bits, addressed by {ba, row[ROW_LSBS-1:0], col[COL_LSBS-1:0]}.
REQ-016 Per-bank state SHALL be: open_ba[3:0] plus the latched row. ACT opens the bank. PCH closes bank ba, or all banks when a[10]=1.
REQ-017 LMR SHALL latch the mode fields: BL=a[2:0] (000=1, 001=2, 010=4, 011=8, 111=full page), BT=a[3] (0 sequential, 1 interleaved), CL=a[6:4], WB=a[9] (1 = single-location writes).
REQ-018 The mode register SHALL reset to CL=3, BL=1, BT=0, WB=0.
REQ-019 RD/WR SHALL start a burst at column a[COL_LSBS-1:0] with a[10] ignored; one address is generated per cycle.
REQ-020 Sequential bursts SHALL wrap within the aligned BL block; interleaved bursts SHALL use start XOR beat; full page SHALL wrap at 2^COL_LSBS and run until terminated.
REQ-021 A new RD or WR SHALL terminate the current burst immediately; PCH to the burst bank SHALL also terminate it.
REQ-022 Write beat: the write SHALL occur on the same edge as the beat; dqm bit high skips that byte (write dqm latency 0).
REQ-023 Read beat: the address enters a CL-deep pipeline; dq_o/dq_oe_o SHALL update at edge CL-1 after the RD sample edge, so the controller samples the word at edge CL.
REQ-024 Read dqm latency SHALL be 2: dqm sampled at edge n forces dq_oe_o=0 for the word sampled at edge n+2.
REQ-025 Read words already in the pipeline SHALL still be delivered after a burst is terminated.
REQ-026 A WR issued while read words are in flight SHALL flush the pipeline (dq_oe_o=0 from the next edge).
REQ-027 err[0]: ACT to an already-open bank.
REQ-028 err[1]: RD/WR to a closed bank.
REQ-029 err[2]: RFR or LMR while any bank is open.
REQ-030 err[3]: LMR with CL not 2 or 3, BL reserved, or full page with BT=1; the illegal value is ignored and the previous mode is kept.
REQ-031 err[4]: ACT/RD/WR before init_done.
REQ-032 init_done SHALL set on LMR when at least two RFR have been seen since reset.
REQ-033 When a read and a write target the same address on one edge, the read SHALL return the old data.

Reset
REQ-034 On sdram_rst: dq_o=0, dq_oe_o=0, init_done=0, rfr_cnt=0, err=0, all banks closed, pipeline and burst idle, mode at its defaults.
REQ-035 A reset mid-burst SHALL abort the burst with no further writes and no further dq_oe_o.
REQ-036 Storage contents are not reset.

Structure
REQ-037 Command encodings, mode-field bit positions and err bit indices SHALL live in the shared sdr_16 defines/package, together with the controller's definitions.
REQ-038 Storage SHALL be one sub-module, sdr_16_mem: one write port with 2 byte enables and one synchronous read port.

Verification
REQ-039 Init: reset, PCH a10=1, RFR x2, LMR a=0x022 (CL2, BL4) -> init_done=1 next cycle, rfr_cnt=2, err=0.
REQ-040 Write/read CL2 BL4: ACT ba1 row3; WR col 0x05 with data 0x1111..0x4444, dqm=01 on beat 2; RD col 0x05 -> first word at edge 2, sequence 0x1111, 0x22xx (low byte old), 0x3333, 0x4444 at cols 5,6,7,4.
REQ-041 CL3 read dqm: RD, then dqm=11 on the edge after the RD -> the second word has dq_oe_o=0 and the other three words are valid.
REQ-042 Termination: full-page RD at col 0x3E, new RD at col 0x10 after 3 cycles -> word order 0x3E, 0x3F, 0x00, then 0x10, 0x11, ...
REQ-043 Errors: RD to closed bank2 -> err[1]; ACT to open bank -> err[0]; LMR CL=5 -> err[3] and CL unchanged.
REQ-044 Reset mid-write burst at beat 2 -> beats 3-4 are not written, all outputs at reset values.
